// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants for the instruction encoder and its users.
// Holds the format codes (same values as the controller's ImmSrc), the
// major opcodes, common funct3 values and a signed-range helper.
package rv_pkg;

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_U = 3'b011,
    FMT_J = 3'b100,
    FMT_R = 3'b111
  } fmt_e;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_XORID  = 7'b0001011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // True when v, read as two's complement, fits a signed field of 'bits'
  // bits: everything from bit (bits-1) upward must be a pure sign extension.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (bits - 1));
    return (hi == 32'h0000_0000) || (hi == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and a registered occupancy count.
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   push_i, wdata_i     write side (ignored when full)
//   pop_i, rdata_o      read side; rdata_o is the current head (ignored when empty)
//   full_o, empty_o     status from the registered count
//   count_o             number of stored entries
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/rv_instr_encoder.sv
// Streaming RV32I instruction encoder used to load programs into IMEM.
// Field bundles are packed into instruction words, range-checked, buffered
// in a small FIFO and written to IMEM at sequential word addresses.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   in_valid/in_ready          field bundle handshake
//   fmt, opcode, funct3, funct7, rd, rs1, rs2, imm   instruction fields
//   mem_we/mem_ready           IMEM write handshake
//   mem_addr, mem_wdata        IMEM byte address and encoded word
//   flush, done                end-of-program request and indication
//   err, err_count             reject pulse and saturating reject count
//   wrapped                    sticky, address counter has wrapped
module rv_instr_encoder
  import rv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        flush,
  output logic        done,
  output logic        err,
  output logic [7:0]  err_count,
  output logic        wrapped
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(IMEM_WORDS - 1);

  logic [31:0]   word;
  logic          legal;
  logic          is_shift;
  logic          accept, push, pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  logic [31:0]   addr_d, addr_q;
  logic [IW-1:0] widx_d, widx_q;
  logic          wrapped_d, wrapped_q;
  logic          err_d, err_q;
  logic [7:0]    err_cnt_d, err_cnt_q;
  logic          done_d, done_q;

  // Shift-immediates reuse the I slot: funct7 on top, shamt in imm[4:0].
  assign is_shift = (opcode == OP_ALUI) && ((funct3 == F3_SLL) || (funct3 == F3_SR));

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (fmt_e'(fmt))
      FMT_R: begin
        word  = {funct7, rs2, rs1, funct3, rd, opcode};
        legal = 1'b1;
      end
      FMT_I: begin
        if (is_shift) begin
          word  = {funct7, imm[4:0], rs1, funct3, rd, opcode};
          legal = (imm[31:5] == '0);
        end else begin
          word  = {imm[11:0], rs1, funct3, rd, opcode};
          legal = fits_signed(imm, 12);
        end
      end
      FMT_S: begin
        word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        legal = fits_signed(imm, 12);
      end
      FMT_B: begin
        word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        legal = fits_signed(imm, 13) && !imm[0];
      end
      FMT_U: begin
        word  = {imm[31:12], rd, opcode};
        legal = (imm[11:0] == '0);
      end
      FMT_J: begin
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        legal = fits_signed(imm, 21) && !imm[0];
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

  // Readiness depends only on the registered FIFO count, never on mem_ready.
  assign in_ready = reset && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign mem_we   = !fifo_empty;
  assign pop      = mem_we && mem_ready;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .wdata_i (word),
    .pop_i   (pop),
    .rdata_o (mem_wdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    addr_d    = addr_q;
    widx_d    = widx_q;
    wrapped_d = wrapped_q;
    if (pop) begin
      if (widx_q == LAST_IDX) begin
        addr_d    = BASE_ADDR;
        widx_d    = '0;
        wrapped_d = 1'b1;
      end else begin
        addr_d = addr_q + 32'd4;
        widx_d = widx_q + IW'(1);
      end
    end
    err_d     = accept && !legal;
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    done_d = flush && (fifo_count == '0) && !accept;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q    <= BASE_ADDR;
      widx_q    <= '0;
      wrapped_q <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      widx_q    <= widx_d;
      wrapped_q <= wrapped_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      done_q    <= done_d;
    end
  end

  assign mem_addr  = addr_q;
  assign wrapped   = wrapped_q;
  assign err       = err_q;
  assign err_count = err_cnt_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
module tb_rv_instr_encoder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          IMW   = 4;
  localparam int          DEPTH = 4;

  logic        clk, reset, in_valid, in_ready;
  logic [2:0]  fmt, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        mem_we, mem_ready, flush, done, err, wrapped;
  logic [31:0] mem_addr, mem_wdata;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  rv_instr_encoder #(
    .BASE_ADDR  (BASE),
    .IMEM_WORDS (IMW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .flush     (flush),
    .done      (done),
    .err       (err),
    .err_count (err_count),
    .wrapped   (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: places each field by arithmetic from the ISA layout.
  function automatic bit [31:0] m_enc(input bit [2:0] f, input bit [6:0] op, input bit [2:0] f3,
                                      input bit [6:0] f7, input bit [4:0] d, input bit [4:0] a,
                                      input bit [4:0] b, input bit [31:0] u, output bit ok);
    bit [31:0] w, OP, F3, F7, D, S1, S2;
    int s;
    OP = 32'(op); F3 = 32'(f3); F7 = 32'(f7); D = 32'(d); S1 = 32'(a); S2 = 32'(b);
    s  = int'($signed(u));
    w  = 0;
    ok = 0;
    case (f)
      3'b111: begin
        w = (F7 << 25) | (S2 << 20) | (S1 << 15) | (F3 << 12) | (D << 7) | OP;
        ok = 1;
      end
      3'b000: begin
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          ok = (u >> 5) == 0;
          w  = (F7 << 25) | ((u % 32) << 20) | (S1 << 15) | (F3 << 12) | (D << 7) | OP;
        end else begin
          ok = (s >= -2048) && (s <= 2047);
          w  = ((u % 4096) << 20) | (S1 << 15) | (F3 << 12) | (D << 7) | OP;
        end
      end
      3'b001: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = (((u >> 5) % 128) << 25) | (S2 << 20) | (S1 << 15) | (F3 << 12) | ((u % 32) << 7) | OP;
      end
      3'b010: begin
        ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
        w  = (((u >> 12) % 2) << 31) | (((u >> 5) % 64) << 25) | (S2 << 20) | (S1 << 15) |
             (F3 << 12) | (((u >> 1) % 16) << 8) | (((u >> 11) % 2) << 7) | OP;
      end
      3'b011: begin
        ok = (u % 4096) == 0;
        w  = ((u / 4096) * 4096) | (D << 7) | OP;
      end
      3'b100: begin
        ok = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
        w  = (((u >> 20) % 2) << 31) | (((u >> 1) % 1024) << 21) | (((u >> 11) % 2) << 20) |
             (((u >> 12) % 256) << 12) | (D << 7) | OP;
      end
      default: ok = 0;
    endcase
    return w;
  endfunction

  // Behavioural model state
  bit [31:0] mq[$];
  bit [31:0] m_addr = BASE;
  int        m_widx = 0;
  bit        m_wrapped = 0, m_err = 0, m_done = 0;
  int        m_errcnt = 0;

  always @(posedge clk) begin
    bit acc, pop, dnext, ok;
    bit [31:0] w;
    if (!reset) begin
      mq.delete();
      m_addr = BASE; m_widx = 0; m_wrapped = 0; m_err = 0; m_done = 0; m_errcnt = 0;
    end else begin
      acc   = in_valid && (mq.size() < DEPTH);
      pop   = (mq.size() > 0) && mem_ready;
      dnext = flush && (mq.size() == 0) && !acc;
      m_err = 0;
      if (pop) begin
        void'(mq.pop_front());
        m_widx++;
        if (m_widx == IMW) begin
          m_widx = 0;
          m_wrapped = 1;
        end
        m_addr = BASE + 32'(4 * m_widx);
      end
      if (acc) begin
        w = m_enc(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, ok);
        if (ok) mq.push_back(w);
        else begin
          m_err = 1;
          if (m_errcnt < 255) m_errcnt++;
        end
      end
      m_done = dnext;
    end
  end

  // Cycle-by-cycle comparison against the model
  always begin
    @(posedge clk);
    #2;
    chk("in_ready", 32'(in_ready), 32'(reset && (mq.size() < DEPTH)));
    chk("mem_we", 32'(mem_we), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("mem_wdata", mem_wdata, mq[0]);
    chk("mem_addr", mem_addr, m_addr);
    chk("err", 32'(err), 32'(m_err));
    chk("err_count", 32'(err_count), 32'(m_errcnt));
    chk("wrapped", 32'(wrapped), 32'(m_wrapped));
    chk("done", 32'(done), 32'(m_done));
  end

  task automatic put(input bit [2:0] f, input bit [6:0] op, input bit [2:0] f3, input bit [6:0] f7,
                     input bit [4:0] d, input bit [4:0] a, input bit [4:0] b, input bit [31:0] u);
    @(negedge clk);
    fmt = f; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = a; rs2 = b; imm = u;
    in_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  int bnd[24] = '{0, 4, -4, 5, 2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098, 31, 32,
                  1048574, 1048576, -1048576, -1048578, 32'h12345000, 32'h00001001, 3, 1, -1};

  task automatic rand_fields();
    int r;
    r = int'($urandom_range(0, 10));
    case (r)
      0, 1, 9: fmt = 3'b000;
      2: fmt = 3'b001;
      3: fmt = 3'b010;
      4: fmt = 3'b011;
      5: fmt = 3'b100;
      6: fmt = 3'b111;
      7: fmt = ($urandom_range(0, 1) == 0) ? 3'b101 : 3'b110;
      default: fmt = 3'b000;
    endcase
    opcode = 7'($urandom);
    funct3 = 3'($urandom);
    if (r == 8 || r == 10) begin
      opcode = 7'h13;
      funct3 = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5;
    end
    funct7 = 7'($urandom);
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    case ($urandom_range(0, 3))
      0, 1: imm = 32'(bnd[$urandom_range(0, 23)]);
      2: imm = 32'(int'($urandom_range(0, 8191)) - 4096);
      default: imm = $urandom;
    endcase
  endtask

  initial begin
    bit ok;
    reset = 1'b0; in_valid = 1'b0; mem_ready = 1'b0; flush = 1'b0;
    fmt = 3'b000; opcode = 7'h13; funct3 = 3'b000; funct7 = 7'h00;
    rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd0;

    // Pin the reference encoder to hand-assembled words
    chk("model_addi", m_enc(3'b000, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, ok), 32'h00500093);
    chk("model_sw", m_enc(3'b001, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, ok), 32'h0020A423);
    chk("model_beq", m_enc(3'b010, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, ok), 32'hFE208EE3);
    chk("model_jal", m_enc(3'b100, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, ok), 32'h001000EF);
    void'(m_enc(3'b010, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, ok));
    chk("model_b_odd_illegal", 32'(ok), 32'd0);

    // Reset state
    repeat (2) after_edge();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, BASE);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;

    // addi x1,x0,5
    put(3'b000, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    after_edge();
    chk("addi_we", 32'(mem_we), 32'd1);
    chk("addi_word", mem_wdata, 32'h00500093);
    chk("addi_addr", mem_addr, BASE);
    idle();

    // sw, beq, jal, lui back-to-back, then a fifth word wraps the address
    do_reset();
    put(3'b001, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    after_edge();
    chk("sw_word", mem_wdata, 32'h0020A423);
    chk("sw_addr", mem_addr, BASE);
    put(3'b010, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    after_edge();
    chk("beq_word", mem_wdata, 32'hFE208EE3);
    chk("beq_addr", mem_addr, BASE + 32'd4);
    put(3'b100, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    after_edge();
    chk("jal_word", mem_wdata, 32'h001000EF);
    chk("jal_addr", mem_addr, BASE + 32'd8);
    put(3'b011, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    after_edge();
    chk("lui_word", mem_wdata, 32'h123452B7);
    chk("lui_addr", mem_addr, BASE + 32'd12);
    chk("lui_not_wrapped", 32'(wrapped), 32'd0);
    put(3'b000, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    after_edge();
    chk("wrap_addr", mem_addr, BASE);
    chk("wrap_flag", 32'(wrapped), 32'd1);
    chk("wrap_word", mem_wdata, 32'h00500093);
    idle();

    // Three illegal bundles
    do_reset();
    put(3'b000, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    after_edge();
    chk("ill_i_err", 32'(err), 32'd1);
    chk("ill_i_cnt", 32'(err_count), 32'd1);
    put(3'b010, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    after_edge();
    chk("ill_b_err", 32'(err), 32'd1);
    chk("ill_b_cnt", 32'(err_count), 32'd2);
    put(3'b011, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h00001001);
    after_edge();
    chk("ill_u_err", 32'(err), 32'd1);
    chk("ill_u_cnt", 32'(err_count), 32'd3);
    chk("ill_we", 32'(mem_we), 32'd0);
    idle();
    after_edge();
    chk("ill_err_drop", 32'(err), 32'd0);
    chk("ill_cnt_hold", 32'(err_count), 32'd3);
    chk("ill_addr", mem_addr, BASE);

    // Backpressure: fill the FIFO, hold, then drain with flush
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(3'b000, 7'h13, 3'd0, 7'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i));
      after_edge();
      if (i >= 3) chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    chk("bp_head", mem_wdata, 32'h00000093);
    idle();
    repeat (2) after_edge();
    chk("bp_head_hold", mem_wdata, 32'h00000093);
    chk("bp_addr_hold", mem_addr, BASE);
    @(negedge clk);
    mem_ready = 1'b1;
    flush = 1'b1;
    for (int k = 1; k < 4; k++) begin
      after_edge();
      chk("drain_word", mem_wdata, (32'(k) << 20) | (32'(k + 1) << 7) | 32'h13);
      chk("drain_addr", mem_addr, BASE + 32'(4 * k));
    end
    after_edge();
    chk("drain_empty", 32'(mem_we), 32'd0);
    chk("drain_wrapped", 32'(wrapped), 32'd1);
    chk("drain_done_early", 32'(done), 32'd0);
    after_edge();
    chk("flush_done", 32'(done), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    after_edge();
    chk("flush_done_drop", 32'(done), 32'd0);

    // Reset in the middle of a drain
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) put(3'b111, 7'h33, 3'd0, 7'd0, 5'(i), 5'd1, 5'd2, 32'd0);
    put(3'b000, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096);
    idle();
    mem_ready = 1'b1;
    after_edge();
    chk("mid_we", 32'(mem_we), 32'd1);
    chk("mid_cnt", 32'(err_count), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    after_edge();
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_addr", mem_addr, BASE);
    chk("mid_rst_cnt", 32'(err_count), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 299) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) flush = ~flush;
      rand_fields();
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (3) after_edge();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
